turbo_stream_decoder: RTL

Receive-side companion to the turbo encoder: accepts the serial encoded stream of (systematic, parity1, parity2) triplets, rebuilds each data byte from the systematic bits, and re-encodes it to check both parity streams. Parity2 is checked through the 8-entry interleaver. It sits after the channel/RAM readout. It hands bytes plus per-byte parity-error counts to the downstream consumer. Hard-decision only; no iterative decoding.

---
 rtl/turbo_pkg.sv | 24 ++
 rtl/turbo_stream_decoder_if.sv | 24 ++
 rtl/rsc_parity_gen.sv | 36 +++
 rtl/turbo_stream_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared turbo code constants: interleaver, RSC taps, frame geometry and FSM states.
package turbo_pkg;

   localparam int TRIPLET_BITS   = 3;
   localparam int FRAME_BITS     = 24;
   localparam int FRAME_TRIPLETS = FRAME_BITS / TRIPLET_BITS;

   // 7/5 RSC: feedback 111 (u, s1, s2), feedforward 101 (a, s1, s2)
   localparam logic [2:0] RSC_FB_TAPS = 3'o7;
   localparam logic [2:0] RSC_FF_TAPS = 3'o5;

   localparam logic [2:0] PI [0:7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};

   typedef enum logic [1:0] {
      RECV  = 2'd0,
      CHECK = 2'd1,
      EMIT  = 2'd2
   } state_e;

   function automatic logic [2:0] pi_index(input logic [2:0] i);
      return PI[i];
   endfunction

endpackage

// File: rtl/turbo_stream_decoder_if.sv
// Stream-in / byte-out bundle between the channel readout, the decoder and its consumer.
interface turbo_stream_decoder_if #(
   parameter int BYTE_CNT_W = 8
);
   logic                  serial_in;
   logic                  in_valid;
   logic                  in_ready;
   logic [7:0]            data_out;
   logic                  byte_valid;
   logic [3:0]            p1_err;
   logic [3:0]            p2_err;
   logic                  frame_ok;
   logic [BYTE_CNT_W-1:0] byte_count;

   modport master (
      output serial_in, in_valid,
      input  in_ready, data_out, byte_valid, p1_err, p2_err, frame_ok, byte_count
   );

   modport slave (
      input  serial_in, in_valid,
      output in_ready, data_out, byte_valid, p1_err, p2_err, frame_ok, byte_count
   );
endinterface

// File: rtl/rsc_parity_gen.sv
// One 7/5 recursive systematic constituent: combinational parity of (state, u),
// state advances on en and clears on clr.
module rsc_parity_gen
   import turbo_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic u,
   output logic parity
);

   logic s1_q, s2_q;
   logic a;

   always_comb begin
      a      = u ^ (RSC_FB_TAPS[1] & s1_q) ^ (RSC_FB_TAPS[0] & s2_q);
      parity = (RSC_FF_TAPS[2] & a) ^ (RSC_FF_TAPS[1] & s1_q) ^ (RSC_FF_TAPS[0] & s2_q);
   end

   // NOTE: non-blocking so s2 takes the old s1 while s1 takes a, as the shift register requires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else if (clr) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else if (en) begin
         s2_q <= s1_q;
         s1_q <= a;
      end
   end

endmodule

// File: rtl/turbo_stream_decoder.sv
// Hard-decision turbo stream checker: collects 8 (d, p1, p2) triplets, re-encodes
// with RSC1 on the fly and RSC2 through the interleaver, then emits byte + error counts.
module turbo_stream_decoder
   import turbo_pkg::*;
#(
   parameter int BYTE_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   turbo_stream_decoder_if.slave   bus
);

   localparam logic [1:0] ST_RECV  = RECV;
   localparam logic [1:0] ST_CHECK = CHECK;
   localparam logic [1:0] ST_EMIT  = EMIT;

   localparam logic [1:0] PH_DATA = 2'd0;
   localparam logic [1:0] PH_P1   = 2'd1;
   localparam logic [1:0] PH_P2   = 2'(TRIPLET_BITS - 1);
   localparam logic [2:0] IDX_LAST = 3'(FRAME_TRIPLETS - 1);

   logic [1:0]            state_q, state_d;
   logic [1:0]            phase_q, phase_d;
   logic [2:0]            idx_q, idx_d;
   logic [3:0]            p1_cnt_q, p1_cnt_d;
   logic [3:0]            p2_cnt_q, p2_cnt_d;
   logic [7:0]            sys_buf_q, sys_buf_d;
   logic [7:0]            p2_buf_q, p2_buf_d;
   logic [7:0]            data_q, data_d;
   logic [3:0]            p1_err_q, p1_err_d;
   logic [3:0]            p2_err_q, p2_err_d;
   logic                  frame_ok_q, frame_ok_d;
   logic                  byte_valid_q, byte_valid_d;
   logic [BYTE_CNT_W-1:0] byte_count_q, byte_count_d;

   logic in_ready;
   logic accept;
   logic rsc_clr;
   logic rsc1_en, rsc1_par;
   logic rsc2_en, rsc2_par;

   // Gated by rst so the upstream sees not-ready for the whole reset pulse.
   assign in_ready = (state_q == ST_RECV) && !rst;
   assign accept   = bus.in_valid && in_ready;
   assign rsc_clr  = (state_q == ST_EMIT);
   assign rsc1_en  = accept && (phase_q == PH_P1);
   assign rsc2_en  = (state_q == ST_CHECK);

   rsc_parity_gen u_rsc1 (
      .clk    (clk),
      .rst    (rst),
      .clr    (rsc_clr),
      .en     (rsc1_en),
      .u      (sys_buf_q[idx_q]),
      .parity (rsc1_par)
   );

   rsc_parity_gen u_rsc2 (
      .clk    (clk),
      .rst    (rst),
      .clr    (rsc_clr),
      .en     (rsc2_en),
      .u      (sys_buf_q[pi_index(idx_q)]),
      .parity (rsc2_par)
   );

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned.
      state_d      = state_q;
      phase_d      = phase_q;
      idx_d        = idx_q;
      p1_cnt_d     = p1_cnt_q;
      p2_cnt_d     = p2_cnt_q;
      sys_buf_d    = sys_buf_q;
      p2_buf_d     = p2_buf_q;
      data_d       = data_q;
      p1_err_d     = p1_err_q;
      p2_err_d     = p2_err_q;
      frame_ok_d   = frame_ok_q;
      byte_valid_d = 1'b0;
      byte_count_d = byte_count_q;

      case (state_q)
         ST_RECV: begin
            if (accept) begin
               case (phase_q)
                  PH_DATA: begin
                     sys_buf_d[idx_q] = bus.serial_in;
                     phase_d          = PH_P1;
                  end
                  PH_P1: begin
                     if (bus.serial_in != rsc1_par) p1_cnt_d = p1_cnt_q + 4'd1;
                     phase_d = PH_P2;
                  end
                  default: begin
                     p2_buf_d[idx_q] = bus.serial_in;
                     phase_d         = PH_DATA;
                     if (idx_q == IDX_LAST) begin
                        state_d = ST_CHECK;
                        idx_d   = 3'd0;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
               endcase
            end
         end

         ST_CHECK: begin
            if (rsc2_par != p2_buf_q[idx_q]) p2_cnt_d = p2_cnt_q + 4'd1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_EMIT;
               idx_d   = 3'd0;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end

         ST_EMIT: begin
            data_d       = sys_buf_q;
            p1_err_d     = p1_cnt_q;
            p2_err_d     = p2_cnt_q;
            frame_ok_d   = (p1_cnt_q == 4'd0) && (p2_cnt_q == 4'd0);
            byte_valid_d = 1'b1;
            byte_count_d = byte_count_q + BYTE_CNT_W'(1);
            p1_cnt_d     = 4'd0;
            p2_cnt_d     = 4'd0;
            phase_d      = PH_DATA;
            idx_d        = 3'd0;
            state_d      = ST_RECV;
         end

         default: state_d = ST_RECV;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RECV;
         phase_q      <= PH_DATA;
         idx_q        <= 3'd0;
         p1_cnt_q     <= 4'd0;
         p2_cnt_q     <= 4'd0;
         data_q       <= 8'h00;
         p1_err_q     <= 4'd0;
         p2_err_q     <= 4'd0;
         frame_ok_q   <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_count_q <= '0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         p1_cnt_q     <= p1_cnt_d;
         p2_cnt_q     <= p2_cnt_d;
         data_q       <= data_d;
         p1_err_q     <= p1_err_d;
         p2_err_q     <= p2_err_d;
         frame_ok_q   <= frame_ok_d;
         byte_valid_q <= byte_valid_d;
         byte_count_q <= byte_count_d;
      end
   end

   // NOTE: frame buffers need no reset; every bit is rewritten before CHECK/EMIT reads it.
   always_ff @(posedge clk) begin
      sys_buf_q <= sys_buf_d;
      p2_buf_q  <= p2_buf_d;
   end

   assign bus.in_ready   = in_ready;
   assign bus.data_out   = data_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.p1_err     = p1_err_q;
   assign bus.p2_err     = p2_err_q;
   assign bus.frame_ok   = frame_ok_q;
   assign bus.byte_count = byte_count_q;

endmodule
